// File: rtl/jtag_pkg.sv
// rtl/jtag_pkg.sv - shared TAP state encoding, default opcodes and IR capture constant
package jtag_pkg;

    // Dense 4-bit encoding of the sixteen 1149.1 TAP states; the value is
    // exported as-is on the tap_state debug port.
    typedef enum logic [3:0] {
        TAP_TLR    = 4'h0,
        TAP_RTI    = 4'h1,
        TAP_SELDR  = 4'h2,
        TAP_CAPDR  = 4'h3,
        TAP_SHDR   = 4'h4,
        TAP_EX1DR  = 4'h5,
        TAP_PAUDR  = 4'h6,
        TAP_EX2DR  = 4'h7,
        TAP_UPDDR  = 4'h8,
        TAP_SELIR  = 4'h9,
        TAP_CAPIR  = 4'hA,
        TAP_SHIR   = 4'hB,
        TAP_EX1IR  = 4'hC,
        TAP_PAUIR  = 4'hD,
        TAP_EX2IR  = 4'hE,
        TAP_UPDIR  = 4'hF
    } tap_state_t;

    localparam logic [3:0] IDCODE_OP  = 4'b1110;
    localparam logic [3:0] BYPASS_OP  = 4'b1111;
    localparam logic [3:0] USER_OP    = 4'b1010;

    // Pattern loaded into the IR shift register in CaptureIr; the fixed
    // "01" in the two LSBs lets a host find the IR chain length.
    localparam logic [1:0] IR_CAPTURE = 2'b01;

    localparam int IDCODE_WIDTH = 32;

endpackage

// File: rtl/jtag_tap_fsm.sv
// rtl/jtag_tap_fsm.sv - 1149.1 TAP state machine with decoded action strobes
//
// Ports:
//   tck, trst_n           JTAG clock, asynchronous active-low reset
//   tms                   test mode select, sampled on posedge tck
//   state                 current TAP state
//   capture_dr/shift_dr/update_dr, capture_ir/shift_ir/update_ir
//                         high while the FSM sits in the matching state, so
//                         the action takes effect on the edge leaving it
//   in_reset              high when the next state is TestLogicReset
//                         (entering or remaining there)
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       tck,
    input  logic       trst_n,
    input  logic       tms,
    output tap_state_t state,
    output logic       capture_dr,
    output logic       shift_dr,
    output logic       update_dr,
    output logic       capture_ir,
    output logic       shift_ir,
    output logic       update_ir,
    output logic       in_reset
);

    tap_state_t state_q;
    tap_state_t state_d;

    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            state_q <= TAP_TLR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            TAP_TLR:   state_d = tms ? TAP_TLR   : TAP_RTI;
            TAP_RTI:   state_d = tms ? TAP_SELDR : TAP_RTI;
            TAP_SELDR: state_d = tms ? TAP_SELIR : TAP_CAPDR;
            TAP_CAPDR: state_d = tms ? TAP_EX1DR : TAP_SHDR;
            TAP_SHDR:  state_d = tms ? TAP_EX1DR : TAP_SHDR;
            TAP_EX1DR: state_d = tms ? TAP_UPDDR : TAP_PAUDR;
            TAP_PAUDR: state_d = tms ? TAP_EX2DR : TAP_PAUDR;
            TAP_EX2DR: state_d = tms ? TAP_UPDDR : TAP_SHDR;
            TAP_UPDDR: state_d = tms ? TAP_SELDR : TAP_RTI;
            TAP_SELIR: state_d = tms ? TAP_TLR   : TAP_CAPIR;
            TAP_CAPIR: state_d = tms ? TAP_EX1IR : TAP_SHIR;
            TAP_SHIR:  state_d = tms ? TAP_EX1IR : TAP_SHIR;
            TAP_EX1IR: state_d = tms ? TAP_UPDIR : TAP_PAUIR;
            TAP_PAUIR: state_d = tms ? TAP_EX2IR : TAP_PAUIR;
            TAP_EX2IR: state_d = tms ? TAP_UPDIR : TAP_SHIR;
            TAP_UPDIR: state_d = tms ? TAP_SELDR : TAP_RTI;
            default:   state_d = TAP_TLR;
        endcase
    end

    assign state      = state_q;
    assign capture_dr = (state_q == TAP_CAPDR);
    assign shift_dr   = (state_q == TAP_SHDR);
    assign update_dr  = (state_q == TAP_UPDDR);
    assign capture_ir = (state_q == TAP_CAPIR);
    assign shift_ir   = (state_q == TAP_SHIR);
    assign update_ir  = (state_q == TAP_UPDIR);
    // Looking at the next state lets the IR fall back to IDCODE on the same
    // edge that enters TestLogicReset, not one cycle later.
    assign in_reset   = (state_d == TAP_TLR);

endmodule

// File: rtl/jtag_tap_param.sv
// rtl/jtag_tap_param.sv - parametrised TAP with IDCODE, BYPASS and USER data registers
//
// Build option: JTAG_TDO_NEGEDGE_EN retimes tdo/tdo_en on negedge tck;
// without it they are combinational from the posedge registers.
//
// Ports:
//   tck, trst_n    JTAG clock, asynchronous active-low reset
//   tms, tdi       JTAG inputs, sampled on posedge tck
//   tdo, tdo_en    serial output and its enable (high in ShiftDr/ShiftIr)
//   user_dr_in     value captured under USER in CaptureDr
//   user_dr_out    USER register, loaded in UpdateDr under USER
//   user_update    one-tck pulse in the cycle after user_dr_out loads
//   ir_out         current instruction
//   tap_state      current TAP state (debug)
module jtag_tap_param
    import jtag_pkg::*;
#(
    parameter int                  IR_WIDTH      = 4,
    parameter logic [31:0]         IDCODE_VALUE  = 32'h000FAF01,
    parameter int                  USER_DR_WIDTH = 8,
    parameter logic [IR_WIDTH-1:0] IDCODE_OPCODE = IR_WIDTH'(IDCODE_OP),
    parameter logic [IR_WIDTH-1:0] USER_OPCODE   = IR_WIDTH'(USER_OP)
) (
    input  logic                     tck,
    input  logic                     trst_n,
    input  logic                     tms,
    input  logic                     tdi,
    output logic                     tdo,
    output logic                     tdo_en,
    input  logic [USER_DR_WIDTH-1:0] user_dr_in,
    output logic [USER_DR_WIDTH-1:0] user_dr_out,
    output logic                     user_update,
    output logic [IR_WIDTH-1:0]      ir_out,
    output logic [3:0]               tap_state
);

    // One physical DR shift register wide enough for the longest chain; the
    // selected instruction decides where tdi enters.
    localparam int DR_W = (USER_DR_WIDTH > IDCODE_WIDTH) ? USER_DR_WIDTH : IDCODE_WIDTH;

    localparam logic [DR_W-1:0] ID_MSB_MASK   = DR_W'(1) << (IDCODE_WIDTH - 1);
    localparam logic [DR_W-1:0] USER_MSB_MASK = DR_W'(1) << (USER_DR_WIDTH - 1);
    localparam logic [DR_W-1:0] BYP_MSB_MASK  = DR_W'(1);

    tap_state_t state;
    logic       capture_dr;
    logic       shift_dr;
    logic       update_dr;
    logic       capture_ir;
    logic       shift_ir;
    logic       update_ir;
    logic       in_reset;

    jtag_tap_fsm u_fsm (
        .tck        (tck),
        .trst_n     (trst_n),
        .tms        (tms),
        .state      (state),
        .capture_dr (capture_dr),
        .shift_dr   (shift_dr),
        .update_dr  (update_dr),
        .capture_ir (capture_ir),
        .shift_ir   (shift_ir),
        .update_ir  (update_ir),
        .in_reset   (in_reset)
    );

    logic [IR_WIDTH-1:0]      ir_q,          ir_d;
    logic [IR_WIDTH-1:0]      ir_shift_q,    ir_shift_d;
    logic [DR_W-1:0]          dr_q,          dr_d;
    logic [USER_DR_WIDTH-1:0] user_q,        user_d;
    logic                     user_upd_q,    user_upd_d;

    logic            sel_idcode;
    logic            sel_user;
    logic [DR_W-1:0] dr_msb_mask;

    // IDCODE wins if both opcodes were configured identically; anything
    // unrecognised, all-ones included, falls through to BYPASS.
    assign sel_idcode  = (ir_q == IDCODE_OPCODE);
    assign sel_user    = !sel_idcode && (ir_q == USER_OPCODE);
    assign dr_msb_mask = sel_idcode ? ID_MSB_MASK :
                         sel_user   ? USER_MSB_MASK : BYP_MSB_MASK;

    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            ir_q       <= IDCODE_OPCODE;
            ir_shift_q <= '0;
            dr_q       <= '0;
            user_q     <= '0;
            user_upd_q <= 1'b0;
        end else begin
            ir_q       <= ir_d;
            ir_shift_q <= ir_shift_d;
            dr_q       <= dr_d;
            user_q     <= user_d;
            user_upd_q <= user_upd_d;
        end
    end

    always_comb begin
        ir_shift_d = ir_shift_q;
        ir_d       = ir_q;
        if (capture_ir) begin
            ir_shift_d = IR_WIDTH'(IR_CAPTURE);
        end else if (shift_ir) begin
            ir_shift_d = {tdi, ir_shift_q[IR_WIDTH-1:1]};
        end
        if (in_reset) begin
            ir_d = IDCODE_OPCODE;
        end else if (update_ir) begin
            ir_d = ir_shift_q;
        end
    end

    always_comb begin
        dr_d = dr_q;
        if (capture_dr) begin
            if (sel_idcode) begin
                dr_d = DR_W'(IDCODE_VALUE);
            end else if (sel_user) begin
                dr_d = DR_W'(user_dr_in);
            end else begin
                dr_d = '0;
            end
        end else if (shift_dr) begin
            // Shift right and drop tdi into the top bit of the selected
            // chain; bits above that chain are don't-care.
            dr_d = ((dr_q >> 1) & ~dr_msb_mask) | ({DR_W{tdi}} & dr_msb_mask);
        end
    end

    always_comb begin
        user_d     = user_q;
        user_upd_d = 1'b0;
        if (update_dr && sel_user) begin
            user_d     = dr_q[USER_DR_WIDTH-1:0];
            user_upd_d = 1'b1;
        end
    end

    logic tdo_d;
    logic tdo_en_d;

    assign tdo_d    = shift_ir ? ir_shift_q[0] :
                      shift_dr ? dr_q[0]       : 1'b0;
    assign tdo_en_d = shift_ir | shift_dr;

`ifdef JTAG_TDO_NEGEDGE_EN
    logic tdo_q;
    logic tdo_en_q;

    always_ff @(negedge tck or negedge trst_n) begin
        if (!trst_n) begin
            tdo_q    <= 1'b0;
            tdo_en_q <= 1'b0;
        end else begin
            tdo_q    <= tdo_d;
            tdo_en_q <= tdo_en_d;
        end
    end

    assign tdo    = tdo_q;
    assign tdo_en = tdo_en_q;
`else
    assign tdo    = tdo_d;
    assign tdo_en = tdo_en_d;
`endif

    assign user_dr_out = user_q;
    assign user_update = user_upd_q;
    assign ir_out      = ir_q;
    assign tap_state   = state;

endmodule
